// File: rtl/vga_layer_mixer.sv
`default_nettype none
// ============================================================================
// Module      : vga_layer_mixer
// Description : VGA timing generator combined with a strict-priority layer
//               compositor. Pixel coordinates advance once per pixel_tick.
//               On every tick the layer inputs for the current coordinate are
//               composited, and the result is registered into rgb together
//               with the matching hsync/vsync. Output is therefore exactly
//               one pixel behind the coordinates.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: VGA_LAYER_BLINK_EN
//   Adds input layer_blink and parameter BLINK_FRAMES. A blink phase toggles
//   every BLINK_FRAMES frames. While the phase is 1, any layer whose
//   layer_blink bit is set is treated as transparent.
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   layer_rgb    in   NUM_LAYERS*RGB_W, layer k colour at [k*RGB_W +: RGB_W]
//   layer_ok     in   NUM_LAYERS, layer k opaque at the current pixel
//   layer_mask   in   NUM_LAYERS, layer k globally enabled
//   layer_blink  in   NUM_LAYERS, layer k blinks (VGA_LAYER_BLINK_EN only)
//   pixel_x/_y   out  10 bits each, current pixel coordinates
//   video_on     out  current coordinates lie in the active area
//   pixel_tick   out  one-clk pulse per pixel
//   frame_start  out  pixel_tick at x=0, y=0
//   hsync/vsync  out  active-low sync, aligned with rgb
//   rgb          out  RGB_W, registered composited colour
// ============================================================================
module vga_layer_mixer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIX_DIV    = 4,
    parameter int NUM_LAYERS = 4,
    parameter int RGB_W      = 12,
    parameter logic [RGB_W-1:0] BG_COLOR = '0
`ifdef VGA_LAYER_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 30
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]       layer_ok,
    input  logic [NUM_LAYERS-1:0]       layer_mask,
`ifdef VGA_LAYER_BLINK_EN
    input  logic [NUM_LAYERS-1:0]       layer_blink,
`endif
    output logic [9:0]                  pixel_x,
    output logic [9:0]                  pixel_y,
    output logic                        video_on,
    output logic                        pixel_tick,
    output logic                        frame_start,
    output logic                        hsync,
    output logic                        vsync,
    output logic [RGB_W-1:0]            rgb
);

    // ------------------------------------------------------------------
    // Timing constants
    // ------------------------------------------------------------------
    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // A one-bit divider is kept even for PIX_DIV=1; it then stays at zero,
    // which makes pixel_tick permanently high outside reset.
    localparam int c_DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(PIX_DIV - 1);

    // ------------------------------------------------------------------
    // Pixel clock divider
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (r_div == c_DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Gated by reset so that the tick is low while reset is held.
    logic w_tick;
    assign w_tick     = ~reset & (r_div == c_DIV_LAST);
    assign pixel_tick = w_tick;

    // ------------------------------------------------------------------
    // Pixel coordinate counters
    // ------------------------------------------------------------------
    logic [9:0] r_x;
    logic [9:0] r_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_tick) begin
            if (r_x == c_H_LAST) begin
                r_x <= '0;
                r_y <= (r_y == c_V_LAST) ? 10'd0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign frame_start = w_tick & (r_x == 10'd0) & (r_y == 10'd0);

    logic w_video_on;
    assign w_video_on = (r_x < c_H_ACT) && (r_y < c_V_ACT);
    assign video_on   = w_video_on;

    // Raw (unregistered) sync for the current coordinate, active low.
    logic w_hsync_raw;
    logic w_vsync_raw;
    assign w_hsync_raw = ~((r_x >= c_HS_FIRST) && (r_x <= c_HS_LAST));
    assign w_vsync_raw = ~((r_y >= c_VS_FIRST) && (r_y <= c_VS_LAST));

    // ------------------------------------------------------------------
    // Layer selection
    // ------------------------------------------------------------------
    logic [NUM_LAYERS-1:0] w_select;

`ifdef VGA_LAYER_BLINK_EN
    localparam int c_BLK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_FRAMES - 1);

    logic [c_BLK_W-1:0] r_blink_cnt;   // frame_starts seen, modulo BLINK_FRAMES
    logic               r_blink_seen;  // at least one frame_start since reset
    logic               r_blink_phase;
    logic               w_blink_toggle;
    logic               w_blink_phase;

    // The toggle is applied combinationally on the frame_start tick so the
    // very first pixel of a new blink period already uses the new phase.
    // The first frame after reset never toggles, giving BLINK_FRAMES frames
    // of phase 0 before the first switch.
    assign w_blink_toggle = frame_start & r_blink_seen & (r_blink_cnt == '0);
    assign w_blink_phase  = r_blink_phase ^ w_blink_toggle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_seen  <= 1'b0;
            r_blink_phase <= 1'b0;
        end else if (frame_start) begin
            r_blink_seen  <= 1'b1;
            r_blink_phase <= w_blink_phase;
            r_blink_cnt   <= (r_blink_cnt == c_BLK_LAST) ? '0 : r_blink_cnt + 1'b1;
        end
    end

    assign w_select = layer_ok & layer_mask & ~(layer_blink & {NUM_LAYERS{w_blink_phase}});
`else
    assign w_select = layer_ok & layer_mask;
`endif

    // Strict priority: walk from the highest index down so the lowest
    // selected index is the last assignment and wins.
    logic [RGB_W-1:0] w_mix;

    always_comb begin
        w_mix = BG_COLOR;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (w_select[k]) begin
                w_mix = layer_rgb[k*RGB_W +: RGB_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers: colour and sync captured on the same tick so they
    // stay aligned one pixel behind the coordinates.
    // ------------------------------------------------------------------
    logic [RGB_W-1:0] r_rgb;
    logic             r_hsync;
    logic             r_vsync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (w_tick) begin
            r_rgb   <= w_video_on ? w_mix : '0;
            r_hsync <= w_hsync_raw;
            r_vsync <= w_vsync_raw;
        end
    end

    assign rgb   = r_rgb;
    assign hsync = r_hsync;
    assign vsync = r_vsync;

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_mixer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_layer_mixer
// Description : Self-checking bench for vga_layer_mixer using a reduced
//               frame geometry so that whole frames fit in a short run.
//               Expected values come from plain arithmetic on the number of
//               clocks since reset and from the priority rule applied to the
//               inputs driven on each tick.
//               With VGA_LAYER_BLINK_EN defined the blink feature is also
//               exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_layer_mixer;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 2;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int PD  = 4;
    localparam int NL  = 4;
    localparam int RW  = 12;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam logic [RW-1:0] BG = 12'h00A;
    localparam int WAIT_MAX = HT * VT * PD + 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NL*RW-1:0]  layer_rgb;
    logic [NL-1:0]     layer_ok;
    logic [NL-1:0]     layer_mask;
`ifdef VGA_LAYER_BLINK_EN
    logic [NL-1:0]     layer_blink;
`endif
    logic [9:0]        pixel_x;
    logic [9:0]        pixel_y;
    logic              video_on;
    logic              pixel_tick;
    logic              frame_start;
    logic              hsync;
    logic              vsync;
    logic [RW-1:0]     rgb;

    vga_layer_mixer #(
        .H_ACTIVE   (HA),
        .H_FP       (HFP),
        .H_SYNC     (HS),
        .H_BP       (HBP),
        .V_ACTIVE   (VA),
        .V_FP       (VFP),
        .V_SYNC     (VS),
        .V_BP       (VBP),
        .PIX_DIV    (PD),
        .NUM_LAYERS (NL),
        .RGB_W      (RW),
        .BG_COLOR   (BG)
`ifdef VGA_LAYER_BLINK_EN
        ,
        .BLINK_FRAMES (2)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .layer_rgb   (layer_rgb),
        .layer_ok    (layer_ok),
        .layer_mask  (layer_mask),
`ifdef VGA_LAYER_BLINK_EN
        .layer_blink (layer_blink),
`endif
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .pixel_tick  (pixel_tick),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Clock edges seen with reset low since the last reset.
    int k_model = 0;
    always @(posedge clk) k_model <= reset ? 0 : k_model + 1;

    // Expected registered outputs, refreshed whenever a tick is consumed.
    logic [RW-1:0] exp_rgb;
    logic          exp_hs;
    logic          exp_vs;

    // Reference compositing rule: first opaque and enabled layer, else BG.
    function automatic logic [RW-1:0] mix_ref(input logic [NL*RW-1:0] c,
                                              input logic [NL-1:0] ok,
                                              input logic [NL-1:0] msk);
        for (int i = 0; i < NL; i++) begin
            if (ok[i] && msk[i]) return c[i*RW +: RW];
        end
        return BG;
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        #1;
        exp_rgb = '0;
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
    endtask

    // Advance negedge by negedge until a tick for pixel (x,y) is pending.
    task automatic wait_pix(input int x, input int y, output bit found);
        found = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (pixel_tick === 1'b1 && pixel_x == 10'(x) && pixel_y == 10'(y)) begin
                found = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (pixel_x !== 10'd0) begin errors++; $display("FAIL reset_x got %0d exp 0", pixel_x); end
        checks++; if (pixel_y !== 10'd0) begin errors++; $display("FAIL reset_y got %0d exp 0", pixel_y); end
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", rgb); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", vsync); end
        checks++; if (pixel_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", pixel_tick); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", frame_start); end
    endtask

    // One full frame from reset with random layer inputs every clock.
    task automatic test_timing();
        int n, ex, ey, fs_cnt, hs_low, vs_low;
        bit etick, efs, evid;
        fs_cnt = 0; hs_low = 0; vs_low = 0;
        do_reset(2);
        for (int c = 0; c < HT * VT * PD; c++) begin
            etick = (k_model % PD) == PD - 1;
            n     = k_model / PD;
            ex    = n % HT;
            ey    = (n / HT) % VT;
            evid  = (ex < HA) && (ey < VA);
            efs   = etick && ex == 0 && ey == 0;
            checks++; if (pixel_tick !== etick) begin errors++; $display("FAIL timing_tick k=%0d got %b exp %b", k_model, pixel_tick, etick); end
            checks++; if (pixel_x !== 10'(ex)) begin errors++; $display("FAIL timing_x k=%0d got %0d exp %0d", k_model, pixel_x, ex); end
            checks++; if (pixel_y !== 10'(ey)) begin errors++; $display("FAIL timing_y k=%0d got %0d exp %0d", k_model, pixel_y, ey); end
            checks++; if (frame_start !== efs) begin errors++; $display("FAIL timing_fs k=%0d got %b exp %b", k_model, frame_start, efs); end
            checks++; if (video_on !== evid) begin errors++; $display("FAIL timing_video_on k=%0d got %b exp %b", k_model, video_on, evid); end
            checks++; if (rgb !== exp_rgb) begin errors++; $display("FAIL timing_rgb k=%0d got %h exp %h", k_model, rgb, exp_rgb); end
            checks++; if (hsync !== exp_hs) begin errors++; $display("FAIL timing_hsync k=%0d got %b exp %b", k_model, hsync, exp_hs); end
            checks++; if (vsync !== exp_vs) begin errors++; $display("FAIL timing_vsync k=%0d got %b exp %b", k_model, vsync, exp_vs); end
            if (etick) begin
                fs_cnt += int'(frame_start);
                hs_low += int'(!hsync);
                vs_low += int'(!vsync);
            end
            layer_rgb  = 48'({$urandom, $urandom});
            layer_ok   = 4'($urandom);
            layer_mask = 4'($urandom);
            if (etick) begin
                exp_rgb = evid ? mix_ref(layer_rgb, layer_ok, layer_mask) : '0;
                exp_hs  = !(ex >= HA + HFP && ex < HA + HFP + HS);
                exp_vs  = !(ey >= VA + VFP && ey < VA + VFP + VS);
            end
            @(negedge clk);
        end
        checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count got %0d exp 1", fs_cnt); end
        checks++; if (hs_low != HS * VT) begin errors++; $display("FAIL hsync_low_count got %0d exp %0d", hs_low, HS * VT); end
        checks++; if (vs_low != VS * HT) begin errors++; $display("FAIL vsync_low_count got %0d exp %0d", vs_low, VS * HT); end
    endtask

    // Fixed two-layer scene under three masks; random mask/ok churn between
    // ticks must not disturb the held output.
    task automatic test_priority();
        logic [NL-1:0] masks [3] = '{4'b1111, 4'b1101, 4'b0000};
        logic [RW-1:0] expv  [3] = '{12'hF00, 12'h0F0, BG};
        bit found;
        wait_pix(3, 2, found);
        if (!found) begin checks++; errors++; $display("FAIL priority_wait timeout got none exp tick at 3,2"); return; end
        for (int i = 0; i < 3; i++) begin
            layer_rgb = 48'({$urandom, $urandom});
            layer_rgb[1*RW +: RW] = 12'hF00;
            layer_rgb[2*RW +: RW] = 12'h0F0;
            layer_ok   = 4'b0110;
            layer_mask = masks[i];
            @(negedge clk);
            for (int j = 1; j < PD; j++) begin
                checks++; if (rgb !== expv[i]) begin errors++; $display("FAIL priority_rgb case=%0d j=%0d got %h exp %h", i, j, rgb, expv[i]); end
                layer_mask = 4'($urandom);
                layer_ok   = 4'($urandom);
                @(negedge clk);
            end
            checks++; if (pixel_tick !== 1'b1) begin errors++; $display("FAIL priority_tick case=%0d got %b exp 1", i, pixel_tick); end
        end
    endtask

    task automatic test_blanking();
        bit found;
        wait_pix(HA + HFP, 3, found);
        if (!found) begin checks++; errors++; $display("FAIL blank_h_wait timeout got none exp tick"); return; end
        checks++; if (video_on !== 1'b0) begin errors++; $display("FAIL blank_h_video_on got %b exp 0", video_on); end
        layer_rgb = 48'({$urandom, $urandom}); layer_ok = 4'b1111; layer_mask = 4'b1111;
        @(negedge clk);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank_h_rgb got %h exp 000", rgb); end
        checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL blank_h_hsync got %b exp 0", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL blank_h_vsync got %b exp 1", vsync); end
        wait_pix(HA + HFP + HS, 3, found);
        if (!found) begin checks++; errors++; $display("FAIL blank_hend_wait timeout got none exp tick"); return; end
        @(negedge clk);
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL blank_hend_hsync got %b exp 1", hsync); end
        wait_pix(2, VA + VFP, found);
        if (!found) begin checks++; errors++; $display("FAIL blank_v_wait timeout got none exp tick"); return; end
        @(negedge clk);
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank_v_rgb got %h exp 000", rgb); end
        checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL blank_v_vsync got %b exp 0", vsync); end
    endtask

    task automatic test_midframe_reset();
        bit found;
        wait_pix(10, 5, found);
        if (!found) begin checks++; errors++; $display("FAIL midreset_wait timeout got none exp tick"); return; end
        layer_ok = 4'b1111; layer_mask = 4'b1111;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin errors++; $display("FAIL midreset_xy got %0d,%0d exp 0,0", pixel_x, pixel_y); end
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL midreset_rgb got %h exp 000", rgb); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL midreset_sync got %b%b exp 11", hsync, vsync); end
        checks++; if (pixel_tick !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL midreset_pulses got %b%b exp 00", pixel_tick, frame_start); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        // The tick pending at negedge PD-1 after release is consumed on the
        // PD-th rising edge after release.
        for (int j = 0; j < PD; j++) begin
            checks++; if (pixel_tick !== (j == PD - 1)) begin errors++; $display("FAIL restart_tick j=%0d got %b exp %b", j, pixel_tick, (j == PD - 1)); end
            if (j == PD - 1) begin
                checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL restart_fs got %b exp 1", frame_start); end
                checks++; if (pixel_x !== 10'd0 || pixel_y !== 10'd0) begin errors++; $display("FAIL restart_xy got %0d,%0d exp 0,0", pixel_x, pixel_y); end
            end else begin
                @(negedge clk);
            end
        end
    endtask

`ifdef VGA_LAYER_BLINK_EN
    task automatic test_blink();
        logic [RW-1:0] col;
        logic [RW-1:0] ev;
        bit found;
        do_reset(2);
        col         = 12'($urandom_range(16, 4095));
        layer_rgb   = 48'({$urandom, $urandom});
        layer_rgb[0 +: RW] = col;
        layer_ok    = 4'b0001;
        layer_mask  = 4'b1111;
        layer_blink = 4'b0001;
        for (int f = 0; f < 5; f++) begin
            wait_pix(1, 1, found);
            if (!found) begin checks++; errors++; $display("FAIL blink_wait frame=%0d timeout", f); return; end
            @(negedge clk);
            ev = (((f / 2) % 2) == 0) ? col : BG;
            checks++; if (rgb !== ev) begin errors++; $display("FAIL blink_rgb frame=%0d got %h exp %h", f, rgb, ev); end
        end
        layer_blink = 4'b0000;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        layer_rgb  = '0;
        layer_ok   = '0;
        layer_mask = '0;
`ifdef VGA_LAYER_BLINK_EN
        layer_blink = '0;
`endif
        exp_rgb = '0;
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
        test_reset();
        test_timing();
        test_priority();
        test_blanking();
        test_midframe_reset();
`ifdef VGA_LAYER_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/vga_layer_mixer.md
VGA_LAYER_MIXER -- requirements
Module: vga_layer_mixer

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal front porch/sync/back porch in pixels.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, 10/2/33, vertical front porch/sync/back porch in lines.
REQ-005 Parameter PIX_DIV, 4, clk cycles per pixel; legal range 1..16.
REQ-006 Parameter NUM_LAYERS, 4, overlay layer count; legal range 1..8.
REQ-007 Parameter RGB_W, 12, colour word width.
REQ-008 Parameter BG_COLOR, 0, colour shown where no layer is opaque.
REQ-009 clk  in  1  system clock.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 layer_rgb  in  NUM_LAYERS*RGB_W  layer k colour in bits [k*RGB_W +: RGB_W].
REQ-012 layer_ok  in  NUM_LAYERS  layer k opaque at current pixel.
REQ-013 layer_mask  in  NUM_LAYERS  layer k globally enabled.
REQ-014 pixel_x, pixel_y  out  10 each  current pixel coordinates, counted from 0.
REQ-015 video_on  out  1  current coordinates within the active area.
REQ-016 pixel_tick  out  1  one-clk pulse per pixel.
REQ-017 frame_start  out  1  one-clk pulse on the tick where x=0,y=0.
REQ-018 hsync, vsync  out  1 each  active-low sync, aligned with rgb.
REQ-019 rgb  out  RGB_W  registered composited colour.

Function
REQ-020 Tick divider SHALL count 0..PIX_DIV-1; pixel_tick SHALL be high when count = PIX_DIV-1; if PIX_DIV=1, pixel_tick SHALL be constant high after reset.
REQ-021 pixel_x SHALL advance on pixel_tick and wrap from H_ACTIVE+H_FP+H_SYNC+H_BP-1 to 0, incrementing pixel_y.
REQ-022 pixel_y SHALL wrap from V_ACTIVE+V_FP+V_SYNC+V_BP-1 to 0 on the same tick that pixel_x wraps.
REQ-023 video_on SHALL be combinational: pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-024 Raw hsync SHALL be low for pixel_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; raw vsync likewise on pixel_y.
REQ-025 Layers SHALL present layer_rgb/layer_ok combinationally from pixel_x/pixel_y; the mixer SHALL sample them on pixel_tick.
REQ-026 Selection SHALL be strict priority: the lowest index k with layer_ok[k] & layer_mask[k] wins; if none, BG_COLOR.
REQ-027 When video_on is low at sampling, rgb SHALL be loaded with 0 regardless of layers.
REQ-028 rgb, hsync and vsync SHALL all be registered on the same pixel_tick; latency is exactly one pixel from coordinate to output.
REQ-029 Between ticks, all outputs SHALL hold their value.
REQ-030 layer_mask changes SHALL take effect on the next pixel_tick, never mid-pixel.

Reset
REQ-031 While reset is high: divider, pixel_x and pixel_y SHALL be 0; rgb SHALL be 0; hsync and vsync SHALL be 1; pixel_tick and frame_start SHALL be 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; the first pixel_tick after release SHALL occur PIX_DIV clks after deassertion, at x=0,y=0, with frame_start high.

Configuration
REQ-033 Macro VGA_LAYER_BLINK_EN SHALL add input layer_blink (NUM_LAYERS) and parameter BLINK_FRAMES (default 30).
REQ-034 With VGA_LAYER_BLINK_EN: a frame counter SHALL toggle a blink phase every BLINK_FRAMES frame_start pulses; a layer with layer_blink[k]=1 SHALL be treated as transparent while phase=1; phase SHALL reset to 0.
REQ-035 Without VGA_LAYER_BLINK_EN: no layer_blink port, no frame counter; compositing per REQ-026 only.

Verification
REQ-036 Defaults, reset released -> pixel_tick every 4 clks; hsync low for x=656..751; vsync low for y=490..491; frame = 800x525 ticks; frame_start once per frame.
REQ-037 layer_ok=4'b0110, mask=4'b1111, layer1=12'hF00, layer2=12'h0F0 at active pixel -> rgb=12'hF00 one pixel later.
REQ-038 Same stimulus, mask=4'b1101 -> rgb=12'h0F0; mask=0 -> rgb=BG_COLOR.
REQ-039 Layers opaque at x=700 (blanking) -> rgb=0 with hsync low on the same output pixel.
REQ-040 Reset pulsed at x=300,y=200 -> outputs at reset values; restart at 0,0 with frame_start after 4 clks.
REQ-041 VGA_LAYER_BLINK_EN, BLINK_FRAMES=2, layer_blink[0]=1, only layer0 opaque -> layer0 colour for frames 0-1, BG_COLOR frames 2-3, repeating.
